// File: rtl/l1d_wbuf_pkg.sv
// Shared types and default sizes for the L1D write-back (victim) buffer.
package l1d_wbuf_pkg;

    localparam int unsigned ADDR_W   = 32;
    localparam int unsigned LINE_W   = 256;
    localparam int unsigned OFFSET_W = 5;
    localparam int unsigned TAG_W    = ADDR_W - OFFSET_W;

    typedef enum logic [1:0] {
        IDLE,
        FILL,
        DRAIN,
        RESP
    } wbuf_state_t;

endpackage

// File: rtl/l1d_wbuf_entry.sv
// Single victim-buffer entry: valid bit, line tag and line data, plus lookup compare.
module l1d_wbuf_entry
    import l1d_wbuf_pkg::*;
#(
    parameter int unsigned TagW  = TAG_W,
    parameter int unsigned LineW = LINE_W
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             load_i,
    input  logic             clear_i,
    input  logic [TagW-1:0]  load_tag_i,
    input  logic [LineW-1:0] load_data_i,
    input  logic [TagW-1:0]  lookup_tag_i,
    output logic             valid_o,
    output logic [TagW-1:0]  tag_o,
    output logic [LineW-1:0] data_o,
    output logic             tag_match_o
);

    logic             valid_q;
    logic [TagW-1:0]  tag_q;
    logic [LineW-1:0] data_q;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            valid_q <= 1'b0;
            tag_q   <= '0;
            data_q  <= '0;
        end else if (clear_i) begin
            valid_q <= 1'b0;
        end else if (load_i) begin
            valid_q <= 1'b1;
            tag_q   <= load_tag_i;
            data_q  <= load_data_i;
        end
    end

    assign valid_o     = valid_q;
    assign tag_o       = tag_q;
    assign data_o      = data_q;
    assign tag_match_o = valid_q && (tag_q == lookup_tag_i);

endmodule

// File: rtl/l1d_writeback_buffer.sv
// Single-entry write-back buffer between L1D and memory: absorbs one evicted line,
// drains it when the memory port is idle and serves reads that hit it.
module l1d_writeback_buffer #(
    parameter int unsigned ADDR_W   = 32,
    parameter int unsigned LINE_W   = 256,
    parameter int unsigned OFFSET_W = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cache_read,
    input  logic              cache_write,
    input  logic [ADDR_W-1:0] cache_address,
    input  logic [LINE_W-1:0] cache_wdata,
    output logic [LINE_W-1:0] cache_rdata,
    output logic              cache_resp,
    output logic              pmem_read,
    output logic              pmem_write,
    output logic [ADDR_W-1:0] pmem_address,
    output logic [LINE_W-1:0] pmem_wdata,
    input  logic [LINE_W-1:0] pmem_rdata,
    input  logic              pmem_resp
);

    import l1d_wbuf_pkg::*;

    localparam int unsigned TagW = ADDR_W - OFFSET_W;

    wbuf_state_t       state_q;
    logic [LINE_W-1:0] rdata_q;
    logic [TagW-1:0]   fill_tag_q;

    logic [TagW-1:0]   req_tag;
    logic              entry_valid;
    logic [TagW-1:0]   entry_tag;
    logic [LINE_W-1:0] entry_data;
    logic              entry_hit;
    logic              entry_load;
    logic              entry_clear;
    logic              unused_offset;

    assign req_tag       = cache_address[ADDR_W-1:OFFSET_W];
    assign unused_offset = ^cache_address[OFFSET_W-1:0];

    // A write only lands in the entry when no read competes and the entry is free.
    always_comb begin
        entry_load  = 1'b0;
        entry_clear = 1'b0;
        if (state_q == IDLE && !cache_read && cache_write && !entry_valid) begin
            entry_load = 1'b1;
        end
        if (state_q == DRAIN && pmem_resp) begin
            entry_clear = 1'b1;
        end
    end

    l1d_wbuf_entry #(
        .TagW  (TagW),
        .LineW (LINE_W)
    ) u_entry (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .load_i       (entry_load),
        .clear_i      (entry_clear),
        .load_tag_i   (req_tag),
        .load_data_i  (cache_wdata),
        .lookup_tag_i (req_tag),
        .valid_o      (entry_valid),
        .tag_o        (entry_tag),
        .data_o       (entry_data),
        .tag_match_o  (entry_hit)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            rdata_q    <= '0;
            fill_tag_q <= '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (cache_read && entry_hit) begin
                        rdata_q <= entry_data;
                        state_q <= RESP;
                    end else if (cache_read) begin
                        fill_tag_q <= req_tag;
                        state_q    <= FILL;
                    end else if (cache_write) begin
                        // A full entry drains first; the write is retried back in IDLE.
                        state_q <= entry_valid ? DRAIN : RESP;
                    end else if (entry_valid) begin
                        state_q <= DRAIN;
                    end
                end
                FILL: begin
                    if (pmem_resp) begin
                        rdata_q <= pmem_rdata;
                        state_q <= RESP;
                    end
                end
                DRAIN: begin
                    if (pmem_resp) begin
                        state_q <= IDLE;
                    end
                end
                RESP: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    // Memory-side outputs decode only from registered state.
    always_comb begin
        pmem_address = '0;
        unique case (state_q)
            FILL:    pmem_address = {fill_tag_q, {OFFSET_W{1'b0}}};
            DRAIN:   pmem_address = {entry_tag, {OFFSET_W{1'b0}}};
            default: pmem_address = '0;
        endcase
    end

    assign cache_resp  = (state_q == RESP);
    assign pmem_read   = (state_q == FILL);
    assign pmem_write  = (state_q == DRAIN);
    assign pmem_wdata  = pmem_write ? entry_data : '0;
    assign cache_rdata = rdata_q;

endmodule
